weighted_lock_rr_arbiter: RTL and testbench

Parametrised round-robin arbiter with per-requester weights and grant locking. A requester may win up to weight+1 consecutive accepted grants before priority rotates. A multi-beat transfer can lock the grant to one owner until its last beat. It sits in front of shared core resources such as cache/memory ports and the writeback bus, where plain one-grant-per-turn arbitration is too coarse.

---
 rtl/weighted_lock_rr_arbiter_pkg.sv | 43 ++++
 rtl/weighted_lock_rr_arbiter_if.sv | 41 ++++
 rtl/weighted_lock_rr_arbiter_rr_priority_pick.sv | 28 ++
 rtl/weighted_lock_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_weighted_lock_rr_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/weighted_lock_rr_arbiter_pkg.sv
// Shared definitions for the weighted, lockable round-robin arbiter.
//   idx_width()     : index width that stays >= 1 even for tiny N
//   onehot_to_idx() : binary index of a one-hot (or zero) vector
//   rotl1_oh()      : circular rotate-left-by-one over the low n bits
//   upd_kind_e      : decoded kind of update applied at the next edge
// Vectors are passed at MAX_N width so the helpers serve any arbiter
// size up to MAX_N; callers zero-extend in and truncate out.
package weighted_lock_rr_arbiter_pkg;

  localparam int MAX_N = 64;

  typedef enum logic [1:0] {
    UPD_IDLE      = 2'd0,  // no accepted grant this cycle
    UPD_LOCK_BEAT = 2'd1,  // accepted beat that keeps ownership
    UPD_ACCEPT    = 2'd2   // single accept or last beat of a burst
  } upd_kind_e;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // OR-encoding: exact for one-hot input, 0 for an all-zero vector.
  function automatic int onehot_to_idx(input logic [MAX_N-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // Bit i moves to bit (i+1) mod n; bits at or above n are dropped.
  function automatic logic [MAX_N-1:0] rotl1_oh(input logic [MAX_N-1:0] v,
                                                input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) r[(i + 1) % n] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/weighted_lock_rr_arbiter_if.sv
// Request/grant bundle of the weighted, lockable round-robin arbiter.
//   req_bitmap_i  : one request bit per requester
//   weight_i      : packed per-requester weights, field k at [k*WEIGHT_W +: WEIGHT_W]
//   lock_i        : qualifies update_en_i; accepted beat is not the last
//   update_en_i   : current grant accepted this cycle
//   grant_oh_o    : one-hot grant (zero when nothing requests)
//   grant_idx_o   : binary grant index (0 when no grant)
//   grant_valid_o : a grant is presented
//   locked_o      : lock register state
// Handshake: grant_valid_o acts as "valid" and update_en_i as "ready";
// a grant is consumed exactly on a cycle where both are high, and
// update_en_i with grant_valid_o low has no effect. The grant is
// combinational, so the consumer may sample it and accept in the same cycle.
// master = requester/consumer side, slave = arbiter side.
interface weighted_lock_rr_arbiter_if
  import weighted_lock_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int WEIGHT_W       = 4
) ();
  localparam int IDX_W = idx_width(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0]          req_bitmap_i;
  logic [NUM_REQUESTERS*WEIGHT_W-1:0] weight_i;
  logic                               lock_i;
  logic                               update_en_i;
  logic [NUM_REQUESTERS-1:0]          grant_oh_o;
  logic [IDX_W-1:0]                   grant_idx_o;
  logic                               grant_valid_o;
  logic                               locked_o;

  modport master (
    output req_bitmap_i, weight_i, lock_i, update_en_i,
    input  grant_oh_o, grant_idx_o, grant_valid_o, locked_o
  );

  modport slave (
    input  req_bitmap_i, weight_i, lock_i, update_en_i,
    output grant_oh_o, grant_idx_o, grant_valid_o, locked_o
  );
endinterface

// File: rtl/weighted_lock_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: returns the first set request bit at or
// above the one-hot priority position, wrapping circularly.
//   req      : request vector
//   prio_oh  : one-hot priority pointer
//   grant_oh : one-hot grant, zero when req is zero
// Doubled-request trick: subtracting prio_oh from {req, req} clears the
// lowest set bit at or above the pointer and sets the bits below it, so
// dbl & ~diff isolates that bit; the two halves are folded back together.
module rr_priority_pick
  import weighted_lock_rr_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] prio_oh,
  output logic [N-1:0] grant_oh
);
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] diff;
  logic [2*N-1:0] masked;

  always_comb begin
    dbl      = {req, req};
    diff     = dbl - {{N{1'b0}}, prio_oh};
    masked   = dbl & ~diff;
    grant_oh = masked[N-1:0] | masked[2*N-1:N];
  end
endmodule

// File: rtl/weighted_lock_rr_arbiter.sv
// Weighted round-robin arbiter with grant locking for multi-beat transfers.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : weighted_lock_rr_arbiter_if.slave (requests, weights, lock and
//         accept in; one-hot/index/valid grant and lock state out)
// A requester at the priority position may take weight+1 consecutive
// accepted grants before priority rotates. While locked on an owner that
// still requests, the grant stays on that owner; locked beats spend no credit
// and the burst counts as one accept when its last beat is taken.
module weighted_lock_rr_arbiter
  import weighted_lock_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int WEIGHT_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  weighted_lock_rr_arbiter_if.slave bus
);
  localparam int N     = NUM_REQUESTERS;
  localparam int IDX_W = idx_width(N);
  localparam logic [N-1:0] ONE_OH = {{(N-1){1'b0}}, 1'b1};

  // State
  logic [N-1:0]        prio_oh,    prio_oh_n;
  logic [WEIGHT_W-1:0] credit_cnt, credit_n;
  logic                locked,     locked_n;
  logic [IDX_W-1:0]    lock_idx,   lock_idx_n;

  // Datapath
  logic [N-1:0]        req;
  logic [N-1:0]        rr_grant_oh;
  logic [N-1:0]        grant_oh;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    prio_idx;
  logic                grant_valid;
  logic                lock_hold;
  logic                accept;
  logic [WEIGHT_W-1:0] w;
  upd_kind_e           upd_kind;

  assign req = bus.req_bitmap_i;

  rr_priority_pick #(.N(N)) u_pick (
    .req      (req),
    .prio_oh  (prio_oh),
    .grant_oh (rr_grant_oh)
  );

  // A lock only holds while its owner keeps requesting; once the owner
  // drops, selection falls back to round robin in the same cycle.
  assign lock_hold   = locked & req[lock_idx];
  assign grant_oh    = lock_hold ? (ONE_OH << lock_idx) : rr_grant_oh;
  assign grant_valid = |grant_oh;
  assign grant_idx   = IDX_W'(onehot_to_idx(MAX_N'(grant_oh)));
  assign prio_idx    = IDX_W'(onehot_to_idx(MAX_N'(prio_oh)));
  assign accept      = bus.update_en_i & grant_valid;
  assign w           = bus.weight_i[int'(grant_idx)*WEIGHT_W +: WEIGHT_W];

  always_comb begin
    upd_kind   = UPD_IDLE;
    prio_oh_n  = prio_oh;
    credit_n   = credit_cnt;
    locked_n   = lock_hold;   // abandoned lock clears on the next edge
    lock_idx_n = lock_idx;

    if (accept) begin
      upd_kind = bus.lock_i ? UPD_LOCK_BEAT : UPD_ACCEPT;
    end

    case (upd_kind)
      UPD_LOCK_BEAT: begin
        locked_n   = 1'b1;
        lock_idx_n = grant_idx;
      end
      UPD_ACCEPT: begin
        locked_n = 1'b0;
        if (grant_idx == prio_idx) begin
          // >= so a weight lowered under the running count rotates at once
          if (credit_cnt >= w) begin
            credit_n  = '0;
            prio_oh_n = N'(rotl1_oh(MAX_N'(prio_oh), N));
          end else begin
            credit_n = credit_cnt + WEIGHT_W'(1);
          end
        end else if (w == '0) begin
          // priority holder was idle: winner takes its single turn
          credit_n  = '0;
          prio_oh_n = N'(rotl1_oh(MAX_N'(grant_oh), N));
        end else begin
          // winner becomes priority holder with this accept already counted
          credit_n  = WEIGHT_W'(1);
          prio_oh_n = grant_oh;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_oh    <= ONE_OH;
      credit_cnt <= '0;
      locked     <= 1'b0;
      lock_idx   <= '0;
    end else begin
      prio_oh    <= prio_oh_n;
      credit_cnt <= credit_n;
      locked     <= locked_n;
      lock_idx   <= lock_idx_n;
    end
  end

  assign bus.grant_oh_o    = grant_oh;
  assign bus.grant_idx_o   = grant_idx;
  assign bus.grant_valid_o = grant_valid;
  assign bus.locked_o      = locked;

`ifdef SIMULATION
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant_oh));
  a_grant_subset: assert property (@(posedge clk) disable iff (rst)
    ((grant_oh & ~req) == '0));
  a_prio_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot(prio_oh));
`endif

endmodule

// File: tb/tb_weighted_lock_rr_arbiter.sv
// Bench for weighted_lock_rr_arbiter: directed scenarios followed by random
// traffic. A driver applies inputs just after each rising edge and pushes
// the expected outputs from an index-based reference model; a monitor pops
// and compares on each falling edge.
module tb_weighted_lock_rr_arbiter;
  import weighted_lock_rr_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int WW    = 4;
  localparam int IW    = 2;
  localparam int EXP_W = N + IW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weighted_lock_rr_arbiter_if #(.NUM_REQUESTERS(N), .WEIGHT_W(WW)) bus ();

  weighted_lock_rr_arbiter #(.NUM_REQUESTERS(N), .WEIGHT_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model state ----------------
  int weights [N];
  int m_prio;      // index of the priority holder
  int m_credit;
  bit m_locked;
  int m_lock_idx;

  logic [EXP_W-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for this cycle, then the state after the next edge.
  function automatic void model_step(input bit rst_v, input logic [N-1:0] req,
                                     input bit lk, input bit upd,
                                     output logic [EXP_W-1:0] e);
    int g;
    int w;
    logic [N-1:0] one;
    logic [N-1:0] oh;
    logic [IW-1:0] gi;
    if (rst_v) begin
      m_prio = 0; m_credit = 0; m_locked = 0; m_lock_idx = 0;
    end
    g = -1;
    if (m_locked && req[m_lock_idx]) begin
      g = m_lock_idx;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req[(m_prio + k) % N]) g = (m_prio + k) % N;
      end
    end
    one = 1;
    oh  = (g >= 0) ? (one << g) : '0;
    gi  = (g >= 0) ? IW'(g) : '0;
    e   = {oh, gi, (g >= 0), m_locked};
    if (rst_v) return;
    if (m_locked && !req[m_lock_idx]) m_locked = 0;
    if (upd && g >= 0) begin
      if (lk) begin
        m_locked = 1; m_lock_idx = g;
      end else begin
        m_locked = 0;
        w = weights[g];
        if (g == m_prio) begin
          if (m_credit >= w) begin
            m_credit = 0; m_prio = (g + 1) % N;
          end else begin
            m_credit = m_credit + 1;
          end
        end else if (w == 0) begin
          m_prio = (g + 1) % N; m_credit = 0;
        end else begin
          m_prio = g; m_credit = 1;
        end
      end
    end
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit rst_v, input logic [N-1:0] req,
                       input bit lk, input bit upd);
    logic [EXP_W-1:0] e;
    @(posedge clk);
    #1;
    rst              = rst_v;
    bus.req_bitmap_i = req;
    bus.lock_i       = lk;
    bus.update_en_i  = upd;
    for (int k = 0; k < N; k++) bus.weight_i[k*WW +: WW] = WW'(weights[k]);
    model_step(rst_v, req, lk, upd, e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) drive(1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
    weights[0] = w0; weights[1] = w1; weights[2] = w2; weights[3] = w3;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant_oh",    32'(bus.grant_oh_o),    32'(e[EXP_W-1 -: N]));
        check("grant_idx",   32'(bus.grant_idx_o),   32'(e[IW+1:2]));
        check("grant_valid", 32'(bus.grant_valid_o), 32'(e[1]));
        check("locked",      32'(bus.locked_o),      32'(e[0]));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst              = 1'b1;
    bus.req_bitmap_i = '0;
    bus.weight_i     = '0;
    bus.lock_i       = 1'b0;
    bus.update_en_i  = 1'b0;
    set_weights(0, 0, 0, 0);

    // Plain round robin: grants 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b0, 4'b1111, 1'b0, 1'b1);

    // Weight 2 on requester 1: three grants to 1, then 0, then prio at 1
    set_weights(0, 2, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b0010, 1'b0, 1'b1);
    drive(1'b0, 4'b0011, 1'b0, 1'b1);
    drive(1'b0, 4'b1111, 1'b0, 1'b0);

    // Four-beat lock on 0 with 3 waiting, then grant moves to 3
    set_weights(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b1001, 1'b1, 1'b1);
    drive(1'b0, 4'b1001, 1'b0, 1'b1);
    drive(1'b0, 4'b1001, 1'b0, 1'b0);

    // Abandoned lock on 2
    do_reset();
    drive(1'b0, 4'b0100, 1'b1, 1'b1);
    drive(1'b0, 4'b0110, 1'b0, 1'b0);
    drive(1'b0, 4'b0010, 1'b0, 1'b0);
    drive(1'b0, 4'b0010, 1'b0, 1'b0);

    // Reset mid-credit on requester 3
    set_weights(0, 0, 0, 2);
    do_reset();
    drive(1'b0, 4'b1000, 1'b0, 1'b1);
    drive(1'b1, 4'b1010, 1'b0, 1'b0);
    #1;
    check("async_rst_grant",  32'(bus.grant_oh_o), 32'h2);
    check("async_rst_locked", 32'(bus.locked_o),   32'h0);
    drive(1'b0, 4'b1010, 1'b0, 1'b1);
    drive(1'b0, 4'b1010, 1'b0, 1'b0);

    // Accept with no request is ignored; then lone requester 3 rotates to 0
    for (int i = 0; i < 5; i++) drive(1'b0, 4'b0000, 1'b0, 1'b1);
    set_weights(0, 0, 0, 0);
    drive(1'b0, 4'b1000, 1'b0, 1'b1);
    drive(1'b0, 4'b1111, 1'b0, 1'b0);

    // Random traffic with occasional weight changes and resets
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      if (i % 60 == 0) begin
        for (int k = 0; k < N; k++)
          weights[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                    : int'($urandom_range(0, 3));
      end
      r = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom_range(0, 15));
      drive(($urandom_range(0, 99) == 0), r,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
